instr_sequencer: RTL and testbench

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/instr_sequencer.sv | 74 +++++++
 tb/tb_instr_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// Byte-serial instruction sequencer: fetches opcode bytes over a req/ack memory
// handshake and drives single-cycle ALU/register strobes, with JMP/JZ/HALT control ops.
module instr_sequencer (
  input  logic       clk,
  input  logic       rstN,
  input  logic [7:0] memVal,
  input  logic       memAck,
  input  logic       aluZero,
  output logic [7:0] memAddr,
  output logic       memReq,
  output logic [3:0] aluSel,
  output logic [2:0] rInSel,
  output logic [2:0] rOutSel,
  output logic       rInEn,
  output logic       rOutEn,
  output logic       genConst,
  output logic       halted
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] EXEC  = 3'd2;
  localparam logic [2:0] OPND  = 3'd3;
  localparam logic [2:0] HALT  = 3'd4;

  localparam logic [7:0] OP_HALT = 8'hF1;
  localparam logic [7:0] OP_JMP  = 8'hF2;
  localparam logic [7:0] OP_JZ   = 8'hF3;

  logic [2:0] state;
  logic [7:0] pc;
  logic [7:0] ir;
  logic       isExec;

  // ir latches every fetched byte so OPND can tell JMP from JZ.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state <= IDLE;
      pc    <= 8'h00;
      ir    <= 8'h00;
    end else begin
      case (state)
        IDLE:  state <= FETCH;
        FETCH: if (memAck) begin
          ir <= memVal;
          pc <= pc + 8'h01;
          if (memVal[7:4] != 4'hF)                         state <= EXEC;
          else if (memVal == OP_HALT)                      state <= HALT;
          else if (memVal == OP_JMP || memVal == OP_JZ)    state <= OPND;
          else                                             state <= FETCH;
        end
        EXEC:  state <= FETCH;
        OPND:  if (memAck) begin
          pc    <= (ir == OP_JMP || aluZero) ? memVal : pc + 8'h01;
          state <= FETCH;
        end
        HALT:  state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

  assign isExec   = (state == EXEC);
  assign memReq   = (state == FETCH) || (state == OPND);
  assign memAddr  = pc;
  assign halted   = (state == HALT);
  assign aluSel   = isExec ? ir[7:4] : 4'h0;
  assign rInSel   = 3'b000;
  assign rOutSel  = isExec ? ir[2:0] : 3'b000;
  assign rInEn    = isExec;
  assign rOutEn   = isExec & ~ir[3];
  assign genConst = isExec &  ir[3];

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench: a program interpreter predicts handshake/exec/halt events,
// a negedge monitor pops and compares them as the sequencer produces them.
module tb_instr_sequencer;
  logic       clk = 0;
  logic       rstN = 0;
  logic [7:0] memVal;
  logic       memAck = 0;
  logic       aluZero = 0;
  logic [7:0] memAddr;
  logic       memReq;
  logic [3:0] aluSel;
  logic [2:0] rInSel, rOutSel;
  logic       rInEn, rOutEn, genConst, halted;

  instr_sequencer dut (
    .clk(clk), .rstN(rstN), .memVal(memVal), .memAck(memAck), .aluZero(aluZero),
    .memAddr(memAddr), .memReq(memReq), .aluSel(aluSel), .rInSel(rInSel),
    .rOutSel(rOutSel), .rInEn(rInEn), .rOutEn(rOutEn), .genConst(genConst),
    .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct { int kind; int val; int cyc; } ev_t;
  localparam int EV_MEM = 1, EV_EXE = 2, EV_HLT = 3;

  logic [7:0] mem [256];
  ev_t expQ[$];
  int  tests = 0, fails = 0;
  int  cnt = 0;
  int  ackMode = 3;
  int  reqRun = 0;
  bit  scoreOn = 0, checkCyc = 0, expHalt = 0;
  bit  prevWait = 0, prevHalt = 0;
  logic [7:0] prevAddr = 0;

  assign memVal = mem[memAddr];

  always @(posedge clk or negedge rstN)
    if (!rstN) cnt <= 0;
    else       cnt <= cnt + 1;

  // Memory responder: ack tied high, random, or after 3 waiting cycles.
  always @(posedge clk) begin
    #1;
    case (ackMode)
      0: memAck = 1'b1;
      1: memAck = ($urandom_range(0, 2) != 0);
      2: memAck = (reqRun >= 3);
      default: ;
    endcase
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic observe(input int kind, input int val);
    ev_t e;
    if (expQ.size() == 0) check("spuriousEv", kind, 0);
    else begin
      e = expQ.pop_front();
      check("evKind", kind, e.kind);
      check("evVal", val, e.val);
      if (checkCyc) check("evCycle", cnt, e.cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rstN) begin
      prevWait = 0; prevHalt = 0; reqRun = 0;
    end else begin
      check("rInSelZero", int'(rInSel), 0);
      if (!rInEn) check("idleStrobes", int'({aluSel, rOutSel, rOutEn, genConst}), 0);
      check("constExcl", int'(rOutEn & genConst), 0);
      if (halted) check("haltNoReq", int'(memReq), 0);
      if (prevWait) begin
        check("reqHeld", int'(memReq), 1);
        check("addrHeld", int'(memAddr), int'(prevAddr));
      end
      if (scoreOn) begin
        if (memReq && memAck) observe(EV_MEM, int'(memAddr));
        if (rInEn) observe(EV_EXE, int'({aluSel, rOutSel, rOutEn, genConst}));
        if (halted && !prevHalt) observe(EV_HLT, 0);
      end
      prevWait = memReq && !memAck;
      prevAddr = memAddr;
      prevHalt = halted;
      reqRun   = (memReq && !memAck) ? reqRun + 1 : 0;
    end
  end

  task automatic push(input int kind, input int val, input int cyc);
    ev_t e;
    e.kind = kind; e.val = val; e.cyc = cyc;
    expQ.push_back(e);
  endtask

  // Reference interpreter; cycle stamps assume ack tied high.
  task automatic buildExp(input int maxEv);
    int pc, t;
    logic [7:0] b, op;
    pc = 0; t = 1; expHalt = 0;
    expQ.delete();
    while (expQ.size() < maxEv && !expHalt) begin
      b = mem[pc];
      push(EV_MEM, pc, t); pc = (pc + 1) % 256; t++;
      if (b[7:4] != 4'hF) begin
        push(EV_EXE, int'({b[7:4], b[2:0], ~b[3], b[3]}), t); t++;
      end else if (b == 8'hF1) begin
        push(EV_HLT, 0, t); expHalt = 1;
      end else if (b == 8'hF2 || b == 8'hF3) begin
        op = mem[pc];
        push(EV_MEM, pc, t); t++;
        pc = (b == 8'hF2 || aluZero) ? int'(op) : (pc + 1) % 256;
      end
    end
  endtask

  task automatic fillMem(input logic [7:0] v);
    for (int i = 0; i < 256; i++) mem[i] = v;
  endtask

  task automatic checkReset();
    check("rstReq", int'(memReq), 0);
    check("rstAddr", int'(memAddr), 0);
    check("rstHalted", int'(halted), 0);
    check("rstStrobes", int'({aluSel, rOutSel, rInSel, rInEn, rOutEn, genConst}), 0);
  endtask

  task automatic runProg(input int mode, input logic z, input int maxEv);
    rstN = 0; scoreOn = 0;
    #1 checkReset();
    aluZero = z; ackMode = mode; checkCyc = (mode == 0);
    buildExp(maxEv);
    scoreOn = 1;
    @(posedge clk); #1 rstN = 1;
    for (int i = 0; i < 3000 && expQ.size() > 0; i++) @(posedge clk);
    scoreOn = 0;
    check("drained", expQ.size(), 0);
    if (expHalt) begin
      repeat (20) @(posedge clk);
      @(negedge clk);
      check("haltHeld", int'(halted), 1);
      check("haltReq", int'(memReq), 0);
    end
    @(posedge clk); #1 rstN = 0;
    #1 checkReset();
  endtask

  task automatic asyncTests();
    bit found;
    scoreOn = 0; ackMode = 3; memAck = 0;
    fillMem(8'hF1); mem[0] = 8'h25;
    rstN = 0;
    @(posedge clk); #1 rstN = 1;
    repeat (3) @(posedge clk);
    #2;
    check("waitReq", int'(memReq), 1);
    check("waitAddr", int'(memAddr), 0);
    memAck = 1; rstN = 0;
    #1 checkReset();
    @(posedge clk); #1;
    check("ackIgnoredAddr", int'(memAddr), 0);
    check("ackIgnoredExec", int'(rInEn), 0);
    memAck = 0;
    @(posedge clk); #1 rstN = 1; ackMode = 0;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (rInEn) found = 1;
    end
    check("execSeen", int'(found), 1);
    check("execAlu", int'(aluSel), 2);
    check("execOut", int'(rOutSel), 5);
    #1 rstN = 0;
    #1 checkReset();
    ackMode = 3;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    fillMem(8'hF1);
    repeat (2) @(posedge clk);
    // ALU op with register source, ack tied high
    fillMem(8'hF1); mem[0] = 8'h25; runProg(0, 0, 10);
    // constant source, ack delayed 3 cycles
    fillMem(8'hF1); mem[0] = 8'h3B; runProg(2, 0, 10);
    // JMP, JZ not taken, JZ taken
    fillMem(8'hF1); mem[0] = 8'hF2; mem[1] = 8'h40; runProg(0, 0, 10);
    fillMem(8'hF1); mem[0] = 8'hF3; mem[1] = 8'h40; runProg(0, 0, 10);
    fillMem(8'hF1); mem[0] = 8'hF3; mem[1] = 8'h40; runProg(0, 1, 10);
    // NOP at 0xFF wraps to 0x00
    fillMem(8'hF1); mem[0] = 8'hF2; mem[1] = 8'hFF; mem[255] = 8'hF0; runProg(0, 0, 9);
    // JZ operand at 0xFF, not taken, continues at 0x00
    fillMem(8'hF1); mem[0] = 8'hF2; mem[1] = 8'hFE; mem[254] = 8'hF3; mem[255] = 8'h10;
    runProg(0, 0, 10);
    fillMem(8'hF1); mem[0] = 8'hF7; mem[1] = 8'h9C; runProg(1, 0, 10);
    asyncTests();
    for (int s = 0; s < 12; s++) begin
      for (int i = 0; i < 256; i++) begin
        logic [7:0] r;
        r = 8'($urandom);
        mem[i] = ($urandom_range(0, 3) == 0) ? {4'hF, 1'b0, r[2:0]} : r;
      end
      runProg(s % 3, 1'($urandom_range(0, 1)), 60);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
